// File: rtl/wb_ram_arbiter.sv
// rtl/wb_ram_arbiter.sv - two-master round-robin Wishbone arbiter in front of a single RAM port
module wb_ram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,

  // master 0
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,

  // master 1
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,

  // RAM slave port
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_stall_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
  // The pulse fires in the cycle whose increment would make the count reach TIMEOUT,
  // so err lands on the TIMEOUT-th unacknowledged strobe cycle.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic              granted;
  logic              gnt_cyc;
  logic              gnt_stb;
  logic              timeout_pulse;

  // Select the cyc/stb of whichever master currently owns the slave.
  always_comb begin
    granted = 1'b0;
    gnt_cyc = 1'b0;
    gnt_stb = 1'b0;
    case (state_q)
      ST_GNT0: begin
        granted = 1'b1;
        gnt_cyc = m0_cyc_i;
        gnt_stb = m0_stb_i;
      end
      ST_GNT1: begin
        granted = 1'b1;
        gnt_cyc = m1_cyc_i;
        gnt_stb = m1_stb_i;
      end
      default: begin
        granted = 1'b0;
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
      end
    endcase
    timeout_pulse = granted & gnt_cyc & gnt_stb & ~s_ack_i & (wdog_q == WDOG_LAST);
  end

  // Arbitration, release and watchdog next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          // round-robin: the master that did not hold the bus last time wins
          state_d = last_grant_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!gnt_cyc || timeout_pulse) begin
          // always pass through IDLE so the other master gets a fair look
          state_d      = ST_IDLE;
          last_grant_d = (state_q == ST_GNT1);
          wdog_d       = '0;
        end else if (!gnt_stb || s_ack_i) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  // Route the granted master to the slave and the slave response back; everything else is 0.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      ST_GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        m0_err_o = (s_stall_i & m0_cyc_i & m0_stb_i) | timeout_pulse;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        m1_err_o = (s_stall_i & m1_cyc_i & m1_stb_i) | timeout_pulse;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // State registers; reset leaves last_grant at 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb/tb_wb_ram_arbiter.sv - directed self-checking bench for wb_ram_arbiter
module tb_wb_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_we_i, m1_we_i, s_we_o;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          s_stb_o, s_cyc_o, s_ack_i, s_stall_i;

  int n_checks = 0;
  int n_errors = 0;

  wb_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_stall_i(s_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_cyc"}, 64'(s_cyc_o), 64'd0);
    check({tag, "_adr"}, 64'(s_adr_o), 64'd0);
  endtask

  task automatic expect_grant(input string tag, input int m);
    check({tag, "_cyc"}, 64'(s_cyc_o), 64'd1);
    check({tag, "_adr"}, 64'(s_adr_o), (m == 0) ? 64'h100 : 64'h200);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    m0_adr_i  = 12'h100;  m1_adr_i = 12'h200;
    m0_dat_i  = 32'h0A0A0A0A; m1_dat_i = 32'h0B0B0B0B;
    m0_we_i   = 1'b0;  m1_we_i  = 1'b0;
    m0_sel_i  = 4'hF;  m1_sel_i = 4'hF;
    m0_stb_i  = 1'b1;  m1_stb_i = 1'b0;
    m0_cyc_i  = 1'b1;  m1_cyc_i = 1'b0;
    s_dat_i   = 32'h11111111;
    s_ack_i   = 1'b1;
    s_stall_i = 1'b1;

    // reset holds everything at 0 even with active inputs
    #2;
    check("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    check("rst_s_stb", 64'(s_stb_o), 64'd0);
    check("rst_m0_ack", 64'(m0_ack_o), 64'd0);
    check("rst_m0_err", 64'(m0_err_o), 64'd0);
    check("rst_m0_dat", 64'(m0_dat_o), 64'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0; s_stall_i = 1'b0;
    step();
    step();
    #3 rst_n = 1'b1;
    step();

    // first simultaneous request after reset goes to m0, one cycle later
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    #1 expect_idle("req_idle");
    step();
    #1 expect_grant("first_gnt", 0);
    check("first_stb", 64'(s_stb_o), 64'd1);
    check("first_we", 64'(s_we_o), 64'd0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    #1;
    check("rd_m0_ack", 64'(m0_ack_o), 64'd1);
    check("rd_m1_ack", 64'(m1_ack_o), 64'd0);
    check("rd_m0_dat", 64'(m0_dat_o), 64'hDEADBEEF);
    check("rd_m1_dat", 64'(m1_dat_o), 64'd0);
    s_ack_i = 1'b0;

    // m0 releases while m1 waits: one IDLE cycle, then m1
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1 check("drop_same_cyc", 64'(s_cyc_o), 64'd0);
    step();
    #1 expect_idle("drop_idle");
    step();
    #1 expect_grant("m1_after_drop", 1);

    // round-robin alternation over 8 simultaneous requests
    for (int r = 0; r < 8; r++) begin
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      step();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      #1 expect_idle($sformatf("rr%0d_idle", r));
      step();
      #1 expect_grant($sformatf("rr%0d_gnt", r), (r % 2 == 0) ? 0 : 1);
    end

    // m1 write routed with its controls; m0 sees nothing
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_sel_i = 4'b0011; m1_adr_i = 12'h010; m1_dat_i = 32'h12345678;
    step();
    #1;
    check("wr_cyc", 64'(s_cyc_o), 64'd1);
    check("wr_sel", 64'(s_sel_o), 64'h3);
    check("wr_we", 64'(s_we_o), 64'd1);
    check("wr_adr", 64'(s_adr_o), 64'h010);
    check("wr_dat", 64'(s_dat_o), 64'h12345678);
    s_ack_i = 1'b1; s_dat_i = 32'h55AA55AA;
    #1;
    check("wr_m1_ack", 64'(m1_ack_o), 64'd1);
    check("wr_m0_ack", 64'(m0_ack_o), 64'd0);
    check("wr_m0_err", 64'(m0_err_o), 64'd0);
    check("wr_m0_dat", 64'(m0_dat_o), 64'd0);
    check("wr_m1_dat", 64'(m1_dat_o), 64'h55AA55AA);
    s_ack_i = 1'b0;

    // stall flag becomes an immediate error on the granted master only
    s_stall_i = 1'b1;
    #1;
    check("stall_m1_err", 64'(m1_err_o), 64'd1);
    check("stall_m0_err", 64'(m0_err_o), 64'd0);
    step();
    s_stall_i = 1'b0;
    #1 check("nostall_m1_err", 64'(m1_err_o), 64'd0);

    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m1_sel_i = 4'hF; m1_adr_i = 12'h200;
    step();

    // watchdog: no ack for 16 strobe cycles forces err and a release
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step();
    for (int c = 1; c <= 16; c++) begin
      if (c == 10) begin
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      end
      #1 check($sformatf("wdog_err_c%0d", c), 64'(m0_err_o), (c == 16) ? 64'd1 : 64'd0);
      if (c == 16) check("wdog_cyc_c16", 64'(s_cyc_o), 64'd1);
      if (c != 16) step();
    end
    step();
    #1 expect_idle("wdog_idle");
    check("wdog_idle_err", 64'(m0_err_o), 64'd0);
    step();
    #1 expect_grant("wdog_to_m1", 1);

    // m0 kept cyc through the forced release; it re-arbitrates normally
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    #1 expect_idle("rearb_idle");
    step();
    #1 expect_grant("rearb_m0", 0);

    // asynchronous reset in the middle of a burst
    #2 rst_n = 1'b0;
    #1;
    check("amid_rst_cyc", 64'(s_cyc_o), 64'd0);
    check("amid_rst_stb", 64'(s_stb_o), 64'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step();
    #2 rst_n = 1'b1;
    s_ack_i = 1'b1;
    #1;
    check("late_ack_m0", 64'(m0_ack_o), 64'd0);
    check("late_ack_m1", 64'(m1_ack_o), 64'd0);
    check("post_rst_idle", 64'(s_cyc_o), 64'd0);
    s_ack_i = 1'b0;
    step();
    #1 expect_grant("post_rst_m1", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8/16/32/64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, address width in bits, passed unchanged to the slave.
REQ-003 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter TIMEOUT, default 16, cycles without ack before forced release; legal range at least 2.
REQ-005 SHALL have port clk  input  1  single clock; every register is clocked on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have, for N in {0,1}, port mN_adr_i  input  ADDR_WIDTH  master N address.
REQ-008 SHALL have ports mN_dat_i  input  DATA_WIDTH and mN_dat_o  output  DATA_WIDTH, carrying master N write and read data.
REQ-009 SHALL have ports mN_we_i, mN_stb_i, mN_cyc_i  input  1 each, plus mN_sel_i  input  SELECT_WIDTH, as the master N Wishbone controls.
REQ-010 SHALL have ports mN_ack_o and mN_err_o  output  1 each, giving master N acknowledge and error.
REQ-011 SHALL have slave ports s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o as outputs, widths matching the master ports.
REQ-012 SHALL have slave ports s_dat_i  input  DATA_WIDTH, s_ack_i  input  1 and s_stall_i  input  1; s_stall_i is the RAM port's incorrect-address flag.

Function
REQ-013 SHALL implement a state machine with states IDLE, GNT0 and GNT1, plus a 1-bit last_grant register.
REQ-014 In IDLE, with only mN_cyc_i high, SHALL enter GNTN on the next edge.
REQ-015 In IDLE, with both cyc inputs high, SHALL grant the master not equal to last_grant (round-robin).
REQ-016 In IDLE, SHALL drive every s_* output and every mN_ack_o, mN_err_o and mN_dat_o to 0.
REQ-017 In GNTN, SHALL drive s_* outputs combinationally from master N inputs, with s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i.
REQ-018 In GNTN, SHALL set mN_ack_o = s_ack_i and mN_dat_o = s_dat_i; the non-granted master sees ack, err and dat_o at 0.
REQ-019 In GNTN, SHALL set mN_err_o = s_stall_i & mN_cyc_i & mN_stb_i, or the timeout pulse (REQ-022).
REQ-020 In GNTN, when mN_cyc_i is low, SHALL go to IDLE on the next edge and set last_grant <= N.
REQ-021 SHALL never move directly from GNT0 to GNT1 or back; at least one IDLE cycle always separates grants.
REQ-022 SHALL keep a watchdog counter, width $clog2(TIMEOUT+1), that:
- increments each GNTN cycle with mN_stb_i high and s_ack_i low;
- clears on s_ack_i, on mN_stb_i low, and in IDLE;
- on reaching TIMEOUT, pulses mN_err_o high for 1 cycle, forces IDLE on the next edge, sets last_grant <= N and clears.
REQ-023 A master still holding cyc after a forced release SHALL re-arbitrate normally through IDLE.
REQ-024 Grant latency SHALL be exactly 1 cycle from cyc assertion in IDLE to s_cyc_o high; the arbiter SHALL add no latency to the ack path.
REQ-025 Pipelined bursts SHALL hold the grant for as long as mN_cyc_i stays high, whatever stb does.

Reset
REQ-026 On rst_n low, SHALL immediately (asynchronously) set state IDLE, last_grant 1 and watchdog 0, making every output 0.
REQ-027 A reset during a granted transfer SHALL drop s_cyc_o and s_stb_o in the same cycle; any ack returning after reset release SHALL be ignored because the state is IDLE.
REQ-028 After rst_n deasserts, the first simultaneous request SHALL be granted to m0.

Verification
REQ-029 Bench SHALL check: after reset, both cyc high -> GNT0 one cycle later; m0 reads with RAM ack at cycle 2 -> m0_ack_o = 1, m1_ack_o = 0, m0_dat_o = s_dat_i.
REQ-030 Bench SHALL check: m0 drops cyc while m1 holds cyc -> IDLE for 1 cycle, then GNT1; next simultaneous request -> m0 (alternation over 8 rounds).
REQ-031 Bench SHALL check: m1 write, sel = 4'b0011, adr = 0x010 -> s_sel_o = 4'b0011, s_we_o = 1, s_adr_o = 0x010 while granted; m0 outputs stay 0.
REQ-032 Bench SHALL check: with TIMEOUT = 16 and the slave never acking, granted m0 stb held -> m0_err_o high exactly on cycle 16 of stb, then IDLE, then m1 granted if requesting.
REQ-033 Bench SHALL check: s_stall_i = 1 during a granted strobe -> mN_err_o = 1 in the same cycle; with s_stall_i = 0 -> err 0.
REQ-034 Bench SHALL check: rst_n pulled low mid-burst, between clock edges -> s_cyc_o = 0 immediately; after release, a single m1 request -> GNT1.
